multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multicycle RV32I core. It decodes the latched instruction's opcode/funct fields and sequences the shared datapath through FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK. The shared datapath is one ALU, a unified memory port, the register file, the PC/OldPC/IR registers and the immediate extender. It sits beside the datapath and drives every enable and mux select; it computes no data itself.

## Interface
- Parameters: none. State and select encodings are fixed constants in the shared package.
- `clk` input 1: sole clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `opcode` input 7: IR[6:0].
- `funct3` input 3: IR[14:12].
- `funct7_5` input 1: IR[30].
- `branch_cond` input 1: comparator result for the current funct3 (rs1 vs rs2), valid in BRANCH.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: load PC from result bus.
- `ir_write` output 1: load IR and OldPC←PC.
- `addr_src` output 1: memory address select: 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `alu_src_a` output 2: ALU A select: 0 = PC, 1 = OldPC, 2 = rs1.
- `alu_src_b` output 2: ALU B select: 0 = rs2, 1 = imm_ext, 2 = constant 4.
- `alu_op` output 2: ALU operation: 0 = add, 1 = compare/sub, 2 = by funct3/funct7_5, 3 = pass B.
- `result_src` output 2: result bus select: 0 = ALUOut, 1 = MDR, 2 = ALU result.
- `reg_write` output 1: register file write of rd.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.
- `halted` output 1: core stopped.
- `state` output 4: current state, for debug.

## Operation
- States: RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR_ADDR, JALR_PC, LUI, ALU_WB, HALT.
- Moore outputs; `pc_write`, `ir_write` and `instr_done` are additionally qualified by `mem_ready`/`branch_cond` where noted. Every signal not listed for a state is 0.
- RESET: all outputs 0. Goes to FETCH unconditionally.
- FETCH:
  - Asserts `mem_read`, `addr_src`=0, `alu_src_a`=0, `alu_src_b`=2, `alu_op`=0, `result_src`=2.
  - `ir_write` and `pc_write` are asserted only while `mem_ready`=1.
  - Holds while `mem_ready`=0; otherwise → DECODE.
- DECODE: `alu_src_a`=1, `alu_src_b`=1, `alu_op`=0 (OldPC+imm into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADDR
  - 0110111 → LUI
  - 0010111 → ALU_WB (AUIPC; ALUOut already holds OldPC+imm)
  - 1110011, and any other opcode → HALT (no CSR file; ECALL/EBREAK stop the core)
- EXEC_R: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=2 → ALU_WB.
- EXEC_I: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=2 → ALU_WB.
- LUI: `alu_src_b`=1, `alu_op`=3 → ALU_WB.
- MEM_ADDR: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=0 → MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_read`, `addr_src`=1. Holds until `mem_ready`, then → MEM_WB.
- MEM_WB: `result_src`=1, `reg_write`, `instr_done` → FETCH.
- MEM_WR: `mem_write`, `addr_src`=1. Holds until `mem_ready`; `instr_done` is asserted in the `mem_ready` cycle, then → FETCH.
- BRANCH: `alu_src_a`=2, `alu_src_b`=0, `alu_op`=1, `result_src`=0, `pc_write`=`branch_cond`, `instr_done` → FETCH.
- JAL: `result_src`=0, `pc_write`, `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0 → ALU_WB.
- JALR_ADDR: `alu_src_a`=2, `alu_src_b`=1, `alu_op`=0 → JALR_PC.
- JALR_PC: `result_src`=0, `pc_write`, `alu_src_a`=1, `alu_src_b`=2 → ALU_WB.
- ALU_WB: `result_src`=0, `reg_write`, `instr_done` → FETCH.
- HALT: `halted`=1, all strobes 0. Exits only on reset.

## Timing
- `resetn` low forces RESET immediately, asynchronously, including mid-access or in HALT. All outputs read 0 while in RESET. The first FETCH is in the 2nd cycle after release.
- Base latency with zero wait states, counted from FETCH through the final cycle:
  - Branch: 3 cycles.
  - AUIPC: 3 cycles.
  - Store: 4 cycles.
  - R-type, I-type, LUI, JAL: 4 cycles.
  - Load: 5 cycles.
  - JALR: 5 cycles.
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- During a stall, `mem_read`/`mem_write`/`addr_src` stay stable and no register enable pulses.
- `mem_ready` outside a memory state is ignored.
- `instr_done` is asserted exactly once per retired instruction and never in HALT.

## Structure
- Shared package `core_pkg` holds:
  - opcode localparams (shared with the immediate extender);
  - state encodings (4-bit);
  - `alu_src_a`/`alu_src_b`/`alu_op`/`result_src` encodings.
- No sub-module. Implement as one sequential state register plus a combinational next-state/output block.

## Test plan
- Reset release, `mem_ready`=1, IR=0x00500093 (addi):
  - expect RESET → FETCH → DECODE → EXEC_I → ALU_WB;
  - `reg_write` and `instr_done` high in cycle 5 only.
- Load 0x0000A103 with `mem_ready` low for 3 cycles in MEM_RD:
  - `mem_read`=1 and `addr_src`=1 held for 4 cycles;
  - MEM_WB follows, `result_src`=1.
- Branch 0x00208463:
  - `branch_cond`=1 → `pc_write`=1 in BRANCH;
  - `branch_cond`=0 → `pc_write`=0;
  - both cases take 3 cycles.
- JALR 0x000080E7: sequence FETCH, DECODE, JALR_ADDR, JALR_PC, ALU_WB.
- Illegal opcode 0x0000007F and ECALL 0x00000073:
  - HALT after DECODE, `halted`=1;
  - no further `mem_read`.
- `resetn` asserted while in MEM_WR with `mem_ready`=0: `mem_write` drops to 0 immediately and `state`=RESET.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, control FSM states
// and datapath mux/ALU select codes.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_RD    = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WR    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_ALU_WB    = 4'd14,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [1:0] A_PC       = 2'd0;
  localparam logic [1:0] A_OLDPC    = 2'd1;
  localparam logic [1:0] A_RS1      = 2'd2;

  localparam logic [1:0] B_RS2      = 2'd0;
  localparam logic [1:0] B_IMM      = 2'd1;
  localparam logic [1:0] B_FOUR     = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] ALU_PASSB  = 2'd3;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MDR    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // SYSTEM (ECALL/EBREAK) and unknown opcodes both stop the core.
  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OP_R:      nxt = S_EXEC_R;
      OP_IMM:    nxt = S_EXEC_I;
      OP_LOAD:   nxt = S_MEM_ADDR;
      OP_STORE:  nxt = S_MEM_ADDR;
      OP_BRANCH: nxt = S_BRANCH;
      OP_JAL:    nxt = S_JAL;
      OP_JALR:   nxt = S_JALR_ADDR;
      OP_LUI:    nxt = S_LUI;
      OP_AUIPC:  nxt = S_ALU_WB;
      default:   nxt = S_HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences the shared datapath
// through fetch/decode/execute/memory/writeback and drives every enable and select.
module multicycle_control
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       branch_cond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       addr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_r;
  state_t next_s;

  // The ALU decodes funct3/funct7_5 itself; the sequencer does not need them.
  logic funct_unused_s;
  assign funct_unused_s = ^{funct3, funct7_5};

  assign state = state_r;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_RESET;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and Moore outputs, with mem_ready/branch_cond qualification
  always_comb begin
    next_s     = state_r;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    addr_src   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_r)
      S_RESET: begin
        next_s = S_FETCH;
      end
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          next_s   = S_DECODE;
        end else begin
          next_s   = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        next_s    = decode_next(opcode);
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
        next_s    = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
        next_s    = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b = B_IMM;
        alu_op    = ALU_PASSB;
        next_s    = S_ALU_WB;
      end
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        if (opcode == OP_STORE) begin
          next_s = S_MEM_WR;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          next_s = S_MEM_WB;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_s     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        addr_src  = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_s     = S_FETCH;
        end else begin
          next_s     = S_MEM_WR;
        end
      end
      S_BRANCH: begin
        alu_src_a  = A_RS1;
        alu_op     = ALU_SUB;
        pc_write   = branch_cond;
        instr_done = 1'b1;
        next_s     = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        next_s    = S_ALU_WB;
      end
      S_JALR_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        next_s    = S_JALR_PC;
      end
      S_JALR_PC: begin
        pc_write  = 1'b1;
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        next_s    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_s     = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        next_s = S_HALT;
      end
      default: begin
        next_s = S_RESET;
      end
    endcase
  end

endmodule
